cpu_run_ctl: RTL
================

// Module: cpu_run_ctl
// PURPOSE
//  Run/step sequencer for the single-cycle RISC datapath. Sits between the debounced buttons and the
//  processor: latches the program selection, holds the CPU in reset for a fixed window, then gates
//  execution through a clock enable in free-run or single-step mode. It stops the CPU on a
//  self-loop (halt idiom), a user halt or a cycle-budget timeout, and reports state and cycle count
//  to the display.
// PARAMETERS
//  RST_CYCLES  4          cycles cpu_reset is held high in LOAD (>=1)
//  MAX_CYCLES  1000000    enabled-cycle budget before forced DONE (>=2)
//  CNT_W       32         width of cycles counter
//  PROG_W      4          width of program selector
// PORTS
//  clock_25mhz  in   1       system clock, all state on posedge
//  reset        in   1       async active-high reset
//  start        in   1       1-cycle pulse: run / resume / rerun
//  step         in   1       1-cycle pulse: execute one instruction
//  halt         in   1       1-cycle pulse: pause free-run
//  prog_in      in   PROG_W  program selection, sampled on start/step from IDLE or DONE
//  pc           in   32      current CPU PC (combinational from processor)
//  cpu_reset    out  1       reset to processor PC/regs
//  cpu_en       out  1       clock enable for PC, regfile and memory writes
//  prog_sel     out  PROG_W  latched program selection to regfile
//  cycles       out  CNT_W   count of enabled cycles since last LOAD
//  state        out  3       encoded FSM state (display)
//  done         out  1       high in DONE
//  timeout      out  1       sticky: DONE was reached via budget
// BEHAVIOUR
//  Reset (async, immediate): state=IDLE, cpu_reset=1, cpu_en=0, prog_sel=0, cycles=0, done=0,
//   timeout=0, loop_valid=0. All outputs are registered or decoded from the state register only.
//  States: IDLE=0, LOAD=1, RUN=2, PAUSE=3, STEP=4, DONE=5; codes 6/7 -> IDLE next cycle.
//  Input priority when pulses coincide: halt > step > start.
//  IDLE: cpu_reset=1, cpu_en=0. start or step -> LOAD; latch prog_sel<=prog_in and
//   mode<=run(start)/step(step).
//  LOAD: cpu_reset=1, cpu_en=0 for exactly RST_CYCLES cycles; cycles<=0, loop_valid<=0,
//   timeout<=0. Inputs ignored. Exit -> RUN (mode run) or PAUSE (mode step).
//  RUN: cpu_reset=0, cpu_en=1; halt -> PAUSE (current cycle still enabled, next cycle not).
//  PAUSE: cpu_en=0; step -> STEP; start -> RUN; halt ignored.
//  STEP: cpu_en=1 for exactly one cycle, then -> PAUSE unless a stop condition fires.
//  DONE: cpu_reset=0, cpu_en=0 (machine state left inspectable), done=1; start or step -> LOAD
//   with prog_sel re-latched; halt ignored.
//  Cycle counting: every cycle with cpu_en=1 does cycles<=cycles+1.
//  Self-loop detect: each enabled cycle pc_q<=pc, loop_valid<=1. If cpu_en && loop_valid &&
//   pc==pc_q -> DONE next cycle (that cycle still counts). Priority over halt.
//  Timeout: enabled cycle with cycles==MAX_CYCLES-1 -> DONE next cycle, timeout<=1; final
//   cycles==MAX_CYCLES. If loop and timeout coincide, timeout=1.
//  Stop conditions apply in RUN and STEP alike; cycles never exceeds MAX_CYCLES.
//  Async reset mid-LOAD/RUN/STEP: aborts immediately; no partial enable pulse after release.
//  Latency: start in IDLE at edge N -> cpu_en first high in cycle N+1+RST_CYCLES.
// TESTING
//  1 reset, prog_in=1, start -> cpu_reset high exactly 4 cycles, prog_sel=1, then cpu_en=1, cycles +1/clk.
//  2 RUN with pc 0,4,8,8 -> done=1 next cycle, cpu_en=0, cycles=4, timeout=0, state=5.
//  3 step from IDLE -> LOAD 4 cycles -> PAUSE; 3 step pulses -> exactly 3 single cpu_en cycles, cycles=3.
//  4 MAX_CYCLES=16, pc +4 each cycle -> DONE after 16 enabled cycles, timeout=1, cycles=16.
//  5 RUN, halt+step same cycle -> PAUSE, no STEP; later start -> RUN resumes, cycles continues.
//  6 assert reset mid-RUN (cycles=7) -> same-cycle cpu_en=0, cpu_reset=1, cycles=0, state=0.

Source files
------------

// File: rtl/cpu_run_ctl.sv
// Run/step sequencer for the single-cycle datapath: holds the CPU in reset after a
// program selection, then gates execution via cpu_en in free-run or single-step mode.
module cpu_run_ctl #(
  parameter int RST_CYCLES = 4,
  parameter int MAX_CYCLES = 1000000,
  parameter int CNT_W      = 32,
  parameter int PROG_W     = 4
) (
  input  logic              clock_25mhz,
  input  logic              reset,
  input  logic              start,
  input  logic              step,
  input  logic              halt,
  input  logic [PROG_W-1:0] prog_in,
  input  logic [31:0]       pc,
  output logic              cpu_reset,
  output logic              cpu_en,
  output logic [PROG_W-1:0] prog_sel,
  output logic [CNT_W-1:0]  cycles,
  output logic [2:0]        state,
  output logic              done,
  output logic              timeout
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_RUN   = 3'd2,
    S_PAUSE = 3'd3,
    S_STEP  = 3'd4,
    S_DONE  = 3'd5
  } state_e;

  localparam int LW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [LW-1:0]    LOAD_LAST = LW'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] CYC_LAST  = CNT_W'(MAX_CYCLES - 1);

  state_e              state_q;
  logic [PROG_W-1:0]   prog_sel_q;
  logic                mode_step_q;
  logic [LW-1:0]       load_cnt_q;
  logic [CNT_W-1:0]    cycles_q;
  logic                timeout_q;
  logic                loop_valid_q;
  logic [31:0]         pc_q;

  logic [CNT_W-1:0]    cycles_d;
  logic                loop_hit;
  logic                budget_hit;

  assign cycles_d   = cycles_q + CNT_W'(1);
  assign loop_hit   = loop_valid_q && (pc == pc_q);
  assign budget_hit = (cycles_q == CYC_LAST);

  always_ff @(posedge clock_25mhz or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      prog_sel_q   <= '0;
      mode_step_q  <= 1'b0;
      load_cnt_q   <= '0;
      cycles_q     <= '0;
      timeout_q    <= 1'b0;
      loop_valid_q <= 1'b0;
      pc_q         <= '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (step || start) begin
            state_q     <= S_LOAD;
            prog_sel_q  <= prog_in;
            mode_step_q <= step;
            load_cnt_q  <= '0;
          end
        end
        S_LOAD: begin
          cycles_q     <= '0;
          loop_valid_q <= 1'b0;
          timeout_q    <= 1'b0;
          if (load_cnt_q == LOAD_LAST) begin
            state_q <= mode_step_q ? S_PAUSE : S_RUN;
          end else begin
            load_cnt_q <= load_cnt_q + LW'(1);
          end
        end
        S_RUN, S_STEP: begin
          // Every enabled cycle counts, including the one that triggers a stop.
          cycles_q     <= cycles_d;
          pc_q         <= pc;
          loop_valid_q <= 1'b1;
          if (budget_hit) begin
            timeout_q <= 1'b1;
            state_q   <= S_DONE;
          end else if (loop_hit) begin
            state_q <= S_DONE;
          end else if (state_q == S_STEP || halt) begin
            state_q <= S_PAUSE;
          end
        end
        S_PAUSE: begin
          if (step) begin
            state_q <= S_STEP;
          end else if (start) begin
            state_q <= S_RUN;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Control outputs decode straight from the state register so reset takes effect at once.
  assign cpu_en    = (state_q == S_RUN) || (state_q == S_STEP);
  assign cpu_reset = !((state_q == S_RUN) || (state_q == S_PAUSE) ||
                       (state_q == S_STEP) || (state_q == S_DONE));
  assign done      = (state_q == S_DONE);
  assign prog_sel  = prog_sel_q;
  assign cycles    = cycles_q;
  assign state     = state_q;
  assign timeout   = timeout_q;

endmodule
